// File: rtl/fifo_wr_arbiter.sv
// Purpose : shares the single FIFO write port among NUM_REQ requesters, round-robin with bursts of up to MAX_BURST beats.
// Latency : a word accepted (gnt) in cycle t appears on o_wr_en/o_data_in in cycle t+1; arbitration takes one IDLE cycle.
// Backpressure: a beat is granted only when the FIFO has room counting the write already in flight; stalls never end a burst.
//
// Ports
//   i_clk, i_rst       clock (rising edge), synchronous active-high reset
//   i_req/i_req_data   per-requester valid and word (word i at [i*FIFO_WIDTH +: FIFO_WIDTH])
//   i_req_last         current word of requester i closes its burst
//   o_gnt              one-hot/zero; o_gnt[i]=1 means word i is accepted this cycle
//   i_full/i_almostfull/i_overflow   FIFO status (almostfull = exactly one free slot)
//   o_wr_en/o_data_in  registered FIFO write port
//   o_owner, o_busy    current/last burst owner, high while a burst is open
//   o_err_overflow     sticky: FIFO reported overflow while we were writing
module fifo_wr_arbiter #(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]            i_req_last,
    output logic [NUM_REQ-1:0]            o_gnt,
    input  logic                          i_full,
    input  logic                          i_almostfull,
    input  logic                          i_overflow,
    output logic                          o_wr_en,
    output logic [FIFO_WIDTH-1:0]         o_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    o_owner,
    output logic                          o_busy,
    output logic                          o_err_overflow
);
    localparam int OWN_W = $clog2(NUM_REQ);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [OWN_W-1:0]      r_owner;
    logic [OWN_W-1:0]      w_owner_nxt;
    logic [OWN_W-1:0]      r_rr_ptr;
    logic [OWN_W-1:0]      w_rr_nxt;
    logic [OWN_W-1:0]      w_arb_idx;
    logic                  w_arb_hit;
    int                    w_cand;
    logic [CNT_W-1:0]      r_beat_cnt;
    logic [CNT_W-1:0]      w_beat_nxt;
    logic                  r_wr_en;
    logic                  w_wr_en_nxt;
    logic [FIFO_WIDTH-1:0] r_data_in;
    logic [FIFO_WIDTH-1:0] w_data_nxt;
    logic                  r_err_overflow;
    logic                  w_space;
    logic                  w_final_beat;
    logic [NUM_REQ-1:0]    w_gnt;
    logic [FIFO_WIDTH-1:0] w_words [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_words[i] = i_req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
        end
    end

    // The registered write still in flight will consume the last free slot,
    // so almostfull only blocks when a write is already on the port.
    assign w_space = !i_full && !(i_almostfull && r_wr_en);

    // Burst ends on the requester's last word or on the MAX_BURST-th accepted beat.
    assign w_final_beat = i_req_last[r_owner] || (r_beat_cnt == CNT_W'(MAX_BURST - 1));

    // Round-robin search starting just after the previous owner.
    always_comb begin
        w_arb_idx = '0;
        w_arb_hit = 1'b0;
        w_cand    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_arb_hit && i_req[OWN_W'(w_cand)]) begin
                w_arb_hit = 1'b1;
                w_arb_idx = OWN_W'(w_cand);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_beat_nxt  = r_beat_cnt;
        w_wr_en_nxt = 1'b0;
        w_data_nxt  = r_data_in;
        w_gnt       = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_hit) begin
                    w_owner_nxt = w_arb_idx;
                    w_beat_nxt  = '0;
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!i_req[r_owner]) begin
                    // Owner withdrew: release without taking a beat.
                    w_state_nxt = ST_IDLE;
                    w_rr_nxt    = r_owner;
                end else if (w_space) begin
                    w_gnt[r_owner] = 1'b1;
                    w_wr_en_nxt    = 1'b1;
                    w_data_nxt     = w_words[r_owner];
                    w_beat_nxt     = r_beat_cnt + 1'b1;
                    if (w_final_beat) begin
                        w_state_nxt = ST_IDLE;
                        w_rr_nxt    = r_owner;
                    end
                end
                // No space: hold the burst, beat count unchanged.
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= OWN_W'(NUM_REQ - 1);
            r_owner    <= '0;
            r_beat_cnt <= '0;
            r_wr_en    <= 1'b0;
            r_data_in  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_owner    <= w_owner_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_data_in  <= w_data_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err_overflow <= 1'b0;
        end else if (i_overflow && r_wr_en) begin
            r_err_overflow <= 1'b1;
        end
    end

    assign o_gnt          = w_gnt;
    assign o_wr_en        = r_wr_en;
    assign o_data_in      = r_data_in;
    assign o_owner        = r_owner;
    assign o_busy         = (r_state == ST_BURST);
    assign o_err_overflow = r_err_overflow;

endmodule
